md_unit_ctrl: RTL and testbench

//  Sequencer for the shared multiply/divide resource and the HI/LO register pair, sitting beside the EX stage.

---
 rtl/md_unit_ctrl_pkg.sv | 35 +++
 rtl/md_unit_ctrl_div_iter.sv | 75 +++++++
 rtl/md_unit_ctrl.sv | 129 ++++++++++++
 tb/tb_md_unit_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: md_op bit positions,
// FSM states and the latched-operation record.
package md_unit_ctrl_pkg;

    localparam int unsigned MD_OP_W  = 8;

    // One-hot md_op bus: {mult,multu,div,divu,mfhi,mflo,mthi,mtlo}
    localparam int unsigned OP_MULT  = 7;
    localparam int unsigned OP_MULTU = 6;
    localparam int unsigned OP_DIV   = 5;
    localparam int unsigned OP_DIVU  = 4;
    localparam int unsigned OP_MFHI  = 3;
    localparam int unsigned OP_MFLO  = 2;
    localparam int unsigned OP_MTHI  = 1;
    localparam int unsigned OP_MTLO  = 0;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    typedef struct packed {
        logic        is_div;
        logic        sign_a;
        logic        sign_b;
        logic        div_zero;
        logic [31:0] raw_a;
    } md_op_t;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] x);
        return neg ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/md_unit_ctrl_div_iter.sv
// 32-step restoring divider on unsigned magnitudes. q_o/r_o show the result of
// the step taken this cycle, so they are final in the cycle done_o is high.
module md_unit_ctrl_div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] q_o,
    output logic [31:0] r_o,
    output logic        done_o
);

    logic        busy_q, busy_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [32:0] shifted, diff;
    logic [31:0] quo_step, rem_step;

    always_comb begin
        // A set borrow bit means the trial subtraction failed: keep the shifted remainder.
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, dvs_q};
        if (diff[32]) begin
            rem_step = shifted[31:0];
            quo_step = {quo_q[30:0], 1'b0};
        end else begin
            rem_step = diff[31:0];
            quo_step = {quo_q[30:0], 1'b1};
        end

        busy_d = busy_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = 5'd0;
            quo_d  = a_i;
            rem_d  = 32'd0;
            dvs_d  = b_i;
        end else if (busy_q) begin
            cnt_d = cnt_q + 5'd1;
            quo_d = quo_step;
            rem_d = rem_step;
            if (cnt_q == 5'd31) busy_d = 1'b0;
        end
    end

    // NOTE: every register is assigned with <= so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= 5'd0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // NOTE: pure datapath registers carry no reset; they are always loaded on start before use.
    always_ff @(posedge clk) begin
        quo_q <= quo_d;
        rem_q <= rem_d;
        dvs_q <= dvs_d;
    end

    assign q_o    = quo_step;
    assign r_o    = rem_step;
    assign done_o = busy_q && (cnt_q == 5'd31);

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer beside EX: owns HI/LO, runs mult/div over several
// cycles while holding the pipeline, and serves mthi/mtlo/mfhi/mflo.
module md_unit_ctrl
    import md_unit_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic               ex_stall,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        src_a,
    input  logic [31:0]        src_b,
    output logic               stallreq_md,
    output logic [31:0]        md_rdata,
    output logic [31:0]        hi_o,
    output logic [31:0]        lo_o
);

    md_state_e   state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] prod_q, prod_d;
    md_op_t      op_q, op_d;

    logic        is_div_op, signed_op, start, div_start, div_done, mul_last;
    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b, div_q, div_r;
    logic [63:0] prod_fix;

    assign is_div_op = md_op[OP_DIV] | md_op[OP_DIVU];
    assign signed_op = md_op[OP_MULT] | md_op[OP_DIV];
    assign start     = ex_valid & (md_op[OP_MULT] | md_op[OP_MULTU] | is_div_op);
    assign sign_a    = signed_op & src_a[31];
    assign sign_b    = signed_op & src_b[31];
    assign mag_a     = neg_if(sign_a, src_a);
    assign mag_b     = neg_if(sign_b, src_b);
    assign mul_last  = (count_q == 6'(MUL_LAT - 1));
    assign prod_fix  = (op_q.sign_a ^ op_q.sign_b) ? (~prod_q + 64'd1) : prod_q;

    md_unit_ctrl_div_iter u_div_iter (
        .clk     (clk),
        .rst     (rst),
        .start_i (div_start),
        .a_i     (mag_a),
        .b_i     (mag_b),
        .q_o     (div_q),
        .r_o     (div_r),
        .done_o  (div_done)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        prod_d      = prod_q;
        op_d        = op_q;
        stallreq_md = 1'b0;
        div_start   = 1'b0;

        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    stallreq_md = 1'b1;
                    div_start   = is_div_op;
                    state_d     = MD_BUSY;
                    count_d     = 6'd0;
                    prod_d      = {32'd0, mag_a} * {32'd0, mag_b};
                    op_d        = '{is_div: is_div_op, sign_a: sign_a, sign_b: sign_b,
                                    div_zero: (src_b == 32'd0), raw_a: src_a};
                end else if (ex_valid && !ex_stall) begin
                    if (md_op[OP_MTHI]) hi_d = src_a;
                    if (md_op[OP_MTLO]) lo_d = src_a;
                end
            end
            MD_BUSY: begin
                stallreq_md = 1'b1;
                count_d     = count_q + 6'd1;
                if (op_q.is_div ? div_done : mul_last) begin
                    state_d = MD_DONE;
                    if (!op_q.is_div) begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end else if (op_q.div_zero) begin
                        hi_d = op_q.raw_a;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = neg_if(op_q.sign_a, div_r);
                        lo_d = neg_if(op_q.sign_a ^ op_q.sign_b, div_q);
                    end
                end
            end
            // Stall already released here; hold until EX actually moves so the op is not re-issued.
            MD_DONE: if (!ex_stall) state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        md_rdata = 32'd0;
        if (md_op[OP_MFHI])      md_rdata = hi_q;
        else if (md_op[OP_MFLO]) md_rdata = lo_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            count_q <= 6'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        prod_q <= prod_d;
        op_q   <= op_d;
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed spec cases plus randomized
// mult/div checked against a plain-arithmetic reference model.
module tb_md_unit_ctrl;

    localparam int unsigned MUL_LAT = 2;

    localparam logic [7:0] OP_MULT  = 8'h80;
    localparam logic [7:0] OP_MULTU = 8'h40;
    localparam logic [7:0] OP_DIV   = 8'h20;
    localparam logic [7:0] OP_DIVU  = 8'h10;
    localparam logic [7:0] OP_MFHI  = 8'h08;
    localparam logic [7:0] OP_MFLO  = 8'h04;
    localparam logic [7:0] OP_MTHI  = 8'h02;
    localparam logic [7:0] OP_MTLO  = 8'h01;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_stall = 1'b0;
    logic [7:0]  md_op = 8'h00;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        stallreq_md;
    logic [31:0] md_rdata, hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    md_unit_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_stall    (ex_stall),
        .md_op       (md_op),
        .src_a       (src_a),
        .src_b       (src_b),
        .stallreq_md (stallreq_md),
        .md_rdata    (md_rdata),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    always #5 clk = ~clk;

    // Reference: HI/LO from the architectural definition using 64-bit integer arithmetic.
    task automatic model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = 32'd0;
        lo = 32'd0;
        if (op == OP_MULT || op == OP_MULTU) begin
            p  = (op == OP_MULT) ? 64'(sa * sb) : ({32'd0, a} * {32'd0, b});
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (op == OP_DIV) begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    function automatic int exp_stall(input logic [7:0] op);
        return (op == OP_DIV || op == OP_DIVU) ? 33 : int'(MUL_LAT) + 1;
    endfunction

    // Issue one mult/div from posedge+1 and count stall cycles; ends at posedge+1 back in IDLE.
    task automatic do_md_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int cycles);
        ex_valid = 1'b1;
        md_op    = op;
        src_a    = a;
        src_b    = b;
        cycles   = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stallreq_md) break;
            cycles++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        md_op    = 8'h00;
        src_a    = 32'd0;
        src_b    = 32'd0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        md_op = OP_MFHI;
        @(negedge clk);
        checks++;
        if (stallreq_md !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stallreq_md); end
        checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'd0) begin
            errors++; $display("FAIL reset_hilo got %h/%h want 0/0", hi_o, lo_o);
        end
        checks++;
        if (md_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", md_rdata); end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        md_op = 8'h00;
    endtask

    task automatic test_directed;
        vec_t vecs[6];
        int   cyc;
        vecs[0] = '{OP_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[3] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[4] = '{OP_DIV,   32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
        vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        foreach (vecs[i]) begin
            do_md_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            checks++;
            if (cyc != exp_stall(vecs[i].op)) begin
                errors++; $display("FAIL dir%0d_stall got %0d want %0d", i, cyc, exp_stall(vecs[i].op));
            end
            checks++;
            if (hi_o !== vecs[i].hi || lo_o !== vecs[i].lo) begin
                errors++;
                $display("FAIL dir%0d_hilo got %h/%h want %h/%h", i, hi_o, lo_o, vecs[i].hi, vecs[i].lo);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0]  op;
        logic [31:0] a, b, ehi, elo;
        int          cyc;
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0:       op = OP_MULT;
                1:       op = OP_MULTU;
                2:       op = OP_DIV;
                default: op = OP_DIVU;
            endcase
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            model(op, a, b, ehi, elo);
            do_md_op(op, a, b, cyc);
            checks++;
            if (cyc != exp_stall(op)) begin
                errors++; $display("FAIL rnd%0d_stall op=%h got %0d want %0d", n, op, cyc, exp_stall(op));
            end
            checks++;
            if (hi_o !== ehi || lo_o !== elo) begin
                errors++;
                $display("FAIL rnd%0d_hilo op=%h a=%h b=%h got %h/%h want %h/%h",
                         n, op, a, b, hi_o, lo_o, ehi, elo);
            end
        end
    endtask

    task automatic test_mt_mf;
        ex_valid = 1'b1;
        md_op    = OP_MTHI;
        src_a    = 32'hA5A5_A5A5;
        @(negedge clk);
        checks++;
        if (stallreq_md !== 1'b0) begin errors++; $display("FAIL mthi_stall got %b want 0", stallreq_md); end
        @(posedge clk);
        #1;
        md_op = OP_MFHI;
        src_a = 32'd0;
        @(negedge clk);
        checks++;
        if (md_rdata !== 32'hA5A5_A5A5 || stallreq_md !== 1'b0) begin
            errors++; $display("FAIL mfhi_read got %h stall %b want a5a5a5a5 stall 0", md_rdata, stallreq_md);
        end
        @(posedge clk);
        #1;
        md_op = OP_MTLO;
        src_a = 32'h5A5A_1234;
        @(posedge clk);
        #1;
        md_op = OP_MFLO;
        src_a = 32'd0;
        @(negedge clk);
        checks++;
        if (md_rdata !== 32'h5A5A_1234) begin errors++; $display("FAIL mflo_read got %h want 5a5a1234", md_rdata); end
        @(posedge clk);
        #1;
        md_op    = OP_MTHI;
        src_a    = 32'hDEAD_BEEF;
        ex_stall = 1'b1;
        @(posedge clk);
        #1;
        ex_stall = 1'b0;
        ex_valid = 1'b0;
        md_op    = OP_MTLO;
        @(posedge clk);
        #1;
        ex_valid = 1'b1;
        md_op    = OP_MFHI;
        src_a    = 32'd0;
        @(negedge clk);
        checks++;
        if (md_rdata !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL mthi_stalled got %h want a5a5a5a5", md_rdata);
        end
        checks++;
        if (lo_o !== 32'h5A5A_1234) begin errors++; $display("FAIL mtlo_invalid got %h want 5a5a1234", lo_o); end
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        md_op    = 8'h00;
    endtask

    task automatic test_done_hold;
        int cyc;
        ex_valid = 1'b1;
        ex_stall = 1'b1;
        md_op    = OP_DIVU;
        src_a    = 32'd1000;
        src_b    = 32'd13;
        cyc      = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stallreq_md) break;
            cyc++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (cyc != 33) begin errors++; $display("FAIL hold_stall got %0d want 33", cyc); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (stallreq_md !== 1'b0 || hi_o !== 32'd12 || lo_o !== 32'd76) begin
                errors++;
                $display("FAIL hold_done%0d stall %b hilo %h/%h want 0 0000000c/0000004c", k, stallreq_md, hi_o, lo_o);
            end
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        ex_stall = 1'b0;
        @(posedge clk);
        #1;
        md_op = OP_MTHI;
        src_a = 32'h0BAD_F00D;
        @(negedge clk);
        checks++;
        if (stallreq_md !== 1'b0) begin errors++; $display("FAIL hold_reissue stall %b want 0", stallreq_md); end
        @(posedge clk);
        #1;
        md_op = OP_MFHI;
        src_a = 32'd0;
        @(negedge clk);
        checks++;
        if (md_rdata !== 32'h0BAD_F00D || lo_o !== 32'd76) begin
            errors++; $display("FAIL hold_idle got %h lo %h want 0badf00d lo 0000004c", md_rdata, lo_o);
        end
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        md_op    = 8'h00;
    endtask

    task automatic test_reset_midop;
        int cyc;
        ex_valid = 1'b1;
        md_op    = OP_DIV;
        src_a    = 32'h1234_5678;
        src_b    = 32'd3;
        repeat (11) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stallreq_md !== 1'b1) begin errors++; $display("FAIL midop_busy stall %b want 1", stallreq_md); end
        rst      = 1'b1;
        ex_valid = 1'b0;
        md_op    = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (stallreq_md !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            errors++; $display("FAIL midop_reset stall %b hilo %h/%h want 0 0/0", stallreq_md, hi_o, lo_o);
        end
        @(posedge clk);
        #1;
        do_md_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, cyc);
        checks++;
        if (cyc != 33 || hi_o !== 32'hFFFF_FFFE || lo_o !== 32'hFFFF_FFF2) begin
            errors++;
            $display("FAIL midop_fresh stall %0d hilo %h/%h want 33 fffffffe/fffffff2", cyc, hi_o, lo_o);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mt_mf();
        test_done_hold();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
